cmp_serial_ctrl: RTL and testbench
==================================

Name: cmp_serial_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands using one external 2-bit magnitude comparator slice.
- Feeds the slice one 2-bit digit per cycle, MSB digit first, and stops at the first unequal digit.
- Registers the final equal/greater/less verdict and reports completion with a start/done handshake.
- Sits between a requesting sequencer and a single shared 2-bit comparator instance.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- Derived: NSLICE = WIDTH/2 digits; index register width clog2(NSLICE), minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- slice_a  output  2  digit of A driven to the comparator slice.
- slice_b  output  2  digit of B driven to the comparator slice.
- slice_e  input  1  slice result: equal (combinational, same cycle).
- slice_g  input  1  slice result: slice_a > slice_b.
- slice_l  input  1  slice result: slice_a < slice_b.
- busy  output  1  high in CMP and DONE.
- done  output  1  single-cycle completion pulse.
- e  output  1  registered verdict: a == b.
- g  output  1  registered verdict: a > b.
- l  output  1  registered verdict: a < b.
- err  output  1  slice returned a non-one-hot result.

Behaviour:
- Reset: when rst_n is low at a clock edge, state goes to IDLE. busy, done, e, g, l, err, slice_a and slice_b are all 0. Operand registers and index are cleared. Reset has priority in every state.
- Reset mid-operation: the operation is abandoned, no done pulse is produced, and the verdict reads 0.
- IDLE: busy = 0, slice_a/slice_b = 0.
  - start = 1 at an edge latches a and b, sets idx = NSLICE-1, clears e/g/l/err, and moves to CMP.
  - start = 0: stay in IDLE. The previous verdict is held.
- CMP: busy = 1. slice_a = A_reg[2*idx+1:2*idx] and slice_b = B_reg[2*idx+1:2*idx], driven combinationally from the registers. The slice responds in the same cycle. Decision at the edge ending the cycle:
  - Slice result not exactly one-hot: err <= 1, e/g/l <= 0, go to DONE.
  - slice_g: g <= 1, go to DONE (early exit).
  - slice_l: l <= 1, go to DONE (early exit).
  - slice_e with idx == 0: e <= 1, go to DONE.
  - slice_e with idx > 0: idx <= idx - 1, stay in CMP.
- DONE: done = 1 and busy = 1 for exactly one cycle. slice outputs = 0. Unconditionally return to IDLE. start is ignored in this cycle.
- Verdict hold: e/g/l/err stay stable from DONE until the next accepted start. At most one of e/g/l is 1.
- Latency: with start accepted at edge 0, k digits examined (1..NSLICE), done is high during cycle k+1.
  - Best case: done in cycle 2.
  - Worst case: done in cycle NSLICE+1.
  - Minimum start-to-start spacing is k+2 cycles.
- Operand changes: a/b may change after the accepted start without affecting the result. start asserted while busy is dropped; it is neither queued nor allowed to restart.
- WIDTH = 2: a single CMP cycle, and the index never decrements.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start pulse at cycle 0 -> four CMP cycles with slice_a=slice_b=2,2,1,1. done=1 in cycle 5 with e=1, g=0, l=0, err=0.
- a=0xC0, b=0x40 -> first digit 3 vs 1. done in cycle 2 with g=1, e=l=0. slice outputs return to 0 in cycle 2.
- a=0x12, b=0x13 -> digits 0/0, 1/1, 0/0, 2/3. done in cycle 5 with l=1. Verdict held through 10 further idle cycles.
- start held high continuously with a=0x00, b=0xFF -> l=1 and done in cycle 2. start ignored in DONE; next accept occurs in cycle 3. Changing b to 0x00 during CMP does not alter the latched result.
- rst_n driven low in cycle 3 of a 0xA5/0xA5 compare -> next cycle IDLE, all outputs 0, no done pulse. A fresh start afterward yields e=1 normally.
- Slice model forced to slice_e=slice_g=1 on the second digit -> done in cycle 3 with err=1, e=g=l=0. The next compare with a healthy slice clears err.

Source files
------------

// File: rtl/cmp_serial_ctrl.sv
// Purpose: compares two WIDTH-bit unsigned operands through one shared 2-bit comparator slice, MSB digit first.
// Latency: done pulses k+1 cycles after the accepted start, where k (1..NSLICE) is the number of digits examined.
// Backpressure: start is sampled only in IDLE; a start seen while busy is dropped, never queued.
module cmp_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [1:0]       slice_a,
   output logic [1:0]       slice_b,
   input  logic             slice_e,
   input  logic             slice_g,
   input  logic             slice_l,
   output logic             busy,
   output logic             done,
   output logic             e,
   output logic             g,
   output logic             l,
   output logic             err
);

   localparam int NSLICE = WIDTH / 2;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             e_q, e_d;
   logic             g_q, g_d;
   logic             l_q, l_d;
   logic             err_q, err_d;

   logic [1:0]       dig_a;
   logic [1:0]       dig_b;
   logic             slice_onehot;

   // Select the digit pair addressed by the current index from the latched operands.
   always_comb begin
      dig_a = 2'b00;
      dig_b = 2'b00;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDXW'(i)) begin
            dig_a = a_q[2*i +: 2];
            dig_b = b_q[2*i +: 2];
         end
      end
   end

   // A healthy slice asserts exactly one of equal/greater/less.
   always_comb begin
      case ({slice_e, slice_g, slice_l})
         3'b100, 3'b010, 3'b001: slice_onehot = 1'b1;
         default:                slice_onehot = 1'b0;
      endcase
   end

   // Next-state and datapath updates; anything not assigned below holds its value.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      e_d     = e_q;
      g_d     = g_q;
      l_d     = l_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = IDX_TOP;
               e_d     = 1'b0;
               g_d     = 1'b0;
               l_d     = 1'b0;
               err_d   = 1'b0;
               state_d = ST_CMP;
            end
         end

         ST_CMP: begin
            if (!slice_onehot) begin
               // A broken slice result overrides any verdict.
               err_d   = 1'b1;
               e_d     = 1'b0;
               g_d     = 1'b0;
               l_d     = 1'b0;
               state_d = ST_DONE;
            end else if (slice_g) begin
               g_d     = 1'b1;
               state_d = ST_DONE;
            end else if (slice_l) begin
               l_d     = 1'b1;
               state_d = ST_DONE;
            end else if (idx_q == '0) begin
               e_d     = 1'b1;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q - IDXW'(1);
            end
         end

         ST_DONE: begin
            // start is deliberately not sampled here.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset taking priority everywhere.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         e_q     <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         e_q     <= e_d;
         g_q     <= g_d;
         l_q     <= l_d;
         err_q   <= err_d;
      end
   end

   // Output decode: the slice sees a digit pair only while comparing, zeros otherwise.
   always_comb begin
      busy    = (state_q == ST_CMP) || (state_q == ST_DONE);
      done    = (state_q == ST_DONE);
      slice_a = (state_q == ST_CMP) ? dig_a : 2'b00;
      slice_b = (state_q == ST_CMP) ? dig_b : 2'b00;
      e       = e_q;
      g       = g_q;
      l       = l_q;
      err     = err_q;
   end

endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// Purpose: self-checking bench for cmp_serial_ctrl with a behavioural 2-bit slice and verdict model.
// Latency: expects done in cycle k+1 after the accepted start, k = digits examined.
// Backpressure: exercises start held high and start during busy being dropped.
module tb_cmp_serial_ctrl;

   localparam int W      = 8;
   localparam int NSLICE = W / 2;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   slice_a;
   logic [1:0]   slice_b;
   logic         slice_e;
   logic         slice_g;
   logic         slice_l;
   logic         busy;
   logic         done;
   logic         e;
   logic         g;
   logic         l;
   logic         err;

   logic         fault_en;
   int           checks;
   int           errors;

   cmp_serial_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .slice_a (slice_a),
      .slice_b (slice_b),
      .slice_e (slice_e),
      .slice_g (slice_g),
      .slice_l (slice_l),
      .busy    (busy),
      .done    (done),
      .e       (e),
      .g       (g),
      .l       (l),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External comparator slice; fault_en makes it answer "equal and greater" at once.
   always_comb begin
      slice_e = (slice_a == slice_b);
      slice_g = (slice_a > slice_b);
      slice_l = (slice_a < slice_b);
      if (fault_en) begin
         slice_e = 1'b1;
         slice_g = 1'b1;
         slice_l = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Digit j (1 = most significant) of an operand.
   function automatic logic [1:0] digit(input logic [W-1:0] v, input int j);
      logic [W-1:0] s;
      s = v >> (2 * (NSLICE - j));
      return s[1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one compare from IDLE and checks digits, timing and verdict against the model.
   // fault_at: CMP cycle (1-based) in which the slice misbehaves, or -1 for none.
   task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int fault_at, input string tag);
      int           k;
      int           p;
      int           cyc;
      bit           seen;
      logic         xe, xg, xl, xerr;
      logic [W-1:0] diff;

      diff = ta ^ tb_v;
      if (diff == '0) begin
         k = NSLICE;
      end else begin
         p = 0;
         for (int i = 0; i < W; i++) if (diff[i]) p = i;
         k = NSLICE - p / 2;
      end
      xe   = (ta == tb_v);
      xg   = (ta > tb_v);
      xl   = (ta < tb_v);
      xerr = 1'b0;
      if (fault_at >= 1 && fault_at <= k) begin
         k    = fault_at;
         xerr = 1'b1;
         xe   = 1'b0;
         xg   = 1'b0;
         xl   = 1'b0;
      end

      a     = ta;
      b     = tb_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cyc   = 1;
      seen  = 1'b0;
      while (!seen && cyc <= NSLICE + 2) begin
         fault_en = (cyc == fault_at);
         #1;
         if (done) begin
            seen = 1'b1;
            chk({tag, " done_cycle"}, cyc, k + 1);
            chk({tag, " busy_done"}, busy, 1);
            chk({tag, " e"}, e, xe);
            chk({tag, " g"}, g, xg);
            chk({tag, " l"}, l, xl);
            chk({tag, " err"}, err, xerr);
            chk({tag, " slice_idle"}, {slice_a, slice_b}, 0);
         end else if (cyc <= k) begin
            chk($sformatf("%s busy_c%0d", tag, cyc), busy, 1);
            chk($sformatf("%s slice_a_c%0d", tag, cyc), slice_a, digit(ta, cyc));
            chk($sformatf("%s slice_b_c%0d", tag, cyc), slice_b, digit(tb_v, cyc));
         end
         tick();
         fault_en = 1'b0;
         cyc++;
      end
      fault_en = 1'b0;
      chk({tag, " done_seen"}, seen, 1);
      chk({tag, " idle_after"}, {busy, done}, 0);
      chk({tag, " held"}, {e, g, l, err}, {xe, xg, xl, xerr});
   endtask

   initial begin
      bit           done_hit;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           fa;

      checks   = 0;
      errors   = 0;
      fault_en = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      repeat (3) tick();

      // Reset state.
      chk("reset_outputs", {busy, done, e, g, l, err, slice_a, slice_b}, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_no_start", {busy, done}, 0);

      // Directed cases.
      do_cmp(8'hA5, 8'hA5, -1, "eq_A5");
      do_cmp(8'hC0, 8'h40, -1, "gt_C0_40");
      do_cmp(8'h12, 8'h13, -1, "lt_12_13");
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold_l_%0d", i), {busy, done, e, g, l, err}, 6'b000010);
         tick();
      end

      // start held high: accepted, ignored in DONE, accepted again from IDLE.
      a     = 8'h00;
      b     = 8'hFF;
      start = 1'b1;
      tick();
      chk("hold_c1_busy", {busy, done}, 2'b10);
      chk("hold_c1_slice", {slice_a, slice_b}, 4'b0011);
      tick();
      chk("hold_c2_done", done, 1);
      chk("hold_c2_l", {e, g, l, err}, 4'b0010);
      tick();
      chk("hold_c3_idle", {busy, done}, 0);
      tick();
      chk("hold_c4_cmp", {busy, done}, 2'b10);
      b     = 8'h00;
      start = 1'b0;
      tick();
      chk("hold_c5_done", done, 1);
      chk("hold_c5_l", {e, g, l, err}, 4'b0010);
      tick();

      // Start pulses during busy are dropped.
      a     = 8'h3C;
      b     = 8'h3C;
      start = 1'b1;
      tick();
      a     = 8'hFF;
      b     = 8'h00;
      tick();
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("busy_start_dropped_e", {e, g, l, err}, 4'b1000);
      chk("busy_start_dropped_idle", {busy, done}, 0);

      // Reset in cycle 3 of a compare abandons it.
      a     = 8'hA5;
      b     = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_outputs", {busy, done, e, g, l, err, slice_a, slice_b}, 0);
      done_hit = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_hit = 1'b1;
         tick();
      end
      chk("midrst_no_done", done_hit, 0);
      do_cmp(8'hA5, 8'hA5, -1, "after_rst");

      // Broken slice on the second digit, then a healthy compare clears err.
      do_cmp(8'hA5, 8'hA5, 2, "fault_d2");
      do_cmp(8'h3C, 8'h3C, -1, "fault_clear");

      // Randomized compares against the model.
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, NSLICE)) : -1;
         do_cmp(ra, rb, fa, $sformatf("rnd%0d", n));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
